reg_mux_bank: RTL
=================

// Module: reg_mux_bank
// PURPOSE
//   Parametrised bank of 2**SEL_BITS enable-gated registers with per-entry valid flags.
//   One write port and one pipelined read port; the read port selects an entry through a binary mux tree.
//   Successor to the single enable/reset register and the combinational mux tree.
//   Used as a small weight/state store in the neural datapath.
// PARAMETERS
//   SEL_BITS    3   address width; DEPTH = 2**SEL_BITS entries (local, derived)
//   DATA_WIDTH  8   bits per entry
//   PIPE        0   extra read pipeline stages, 0 or 1; any other value is a elaboration error
// PORTS
//   clk         in   1           rising-edge clock
//   rst_n       in   1           async active-low reset
//   clr         in   1           sync clear of all valid flags
//   wr_en       in   1           write strobe
//   wr_addr     in   SEL_BITS    write index
//   wr_data     in   DATA_WIDTH  write data
//   inv_en      in   1           invalidate strobe (clears one valid flag)
//   inv_addr    in   SEL_BITS    invalidate index
//   rd_en       in   1           read request
//   rd_addr     in   SEL_BITS    read index
//   rd_valid    out  1           read result valid, one-cycle pulse per request
//   rd_data     out  DATA_WIDTH  read data
//   rd_hit      out  1           valid flag of the entry read
// BEHAVIOUR
//   - Reset (rst_n=0, async): all entries 0, all valid flags 0, rd_valid/rd_data/rd_hit 0, pipeline emptied.
//     Reads in flight are dropped. Outputs stay 0 until the first request after rst_n rises.
//   - Priority per edge: clr > wr_en > inv_en.
//     clr=1: all valid flags 0; array not written; a write in the same cycle is discarded.
//     wr_en=1: entry[wr_addr] <= wr_data and valid[wr_addr] <= 1.
//     inv_en=1, inv_addr==wr_addr with wr_en=1: write wins, valid=1.
//     inv_en=1, different address: that flag <= 0.
//   - Read: rd_en sampled at edge N returns the array/valid state as it was before edge N (read-before-write).
//     rd_valid=1 with rd_data/rd_hit in the cycle after edge N+PIPE, i.e. latency 1+PIPE cycles.
//     Fully pipelined: back-to-back rd_en is accepted every cycle. No backpressure.
//   - rd_valid is 0 when there is no request. rd_data/rd_hit then hold their last value; they are not cleared.
//   - Mux tree: SEL_BITS levels, bit i of rd_addr selects at level i (LSB at the leaves).
//     PIPE=1 inserts a register after level floor(SEL_BITS/2), carrying the upper address bits along.
//     SEL_BITS=1 with PIPE=1: register after level 0.
//   - All addresses are in range by construction (DEPTH = 2**SEL_BITS); no wrap or overflow cases.
//   - Single clock domain; all inputs synchronous to clk.
// CONFIGURATION
//   REG_MUX_BANK_BYPASS_EN defined:
//     rd_en with wr_en, wr_addr==rd_addr and clr=0 in the same cycle returns wr_data with rd_hit=1 (write-through).
//     clr=1 in the same cycle: rd_hit=0 and rd_data = old entry (clr has priority, so no bypass).
//   Not defined: pure read-before-write; no comparator logic is built.
// TESTING
//   1. Reset with rst_n=0 mid-read (PIPE=1, read in flight) -> rd_valid never pulses for that read; all outputs 0.
//   2. Write 0xA5 @3, then read @3 next cycle -> rd_valid 1+PIPE cycles later, rd_data=0xA5, rd_hit=1.
//   3. Same cycle: wr 0x3C @5 and rd @5, entry held 0x11 ->
//      0x11/hit per old flag without the macro; 0x3C/hit=1 with REG_MUX_BANK_BYPASS_EN.
//   4. clr with wr_en @2 (0xFF) same cycle -> later read @2 gives old data, rd_hit=0.
//   5. inv_en @4 with wr_en @4 same cycle -> read @4 gives rd_hit=1.
//      Then inv_en @4 alone -> rd_hit=0, data unchanged.
//   6. Eight back-to-back reads @0..7 after writing i*0x11 -> eight consecutive rd_valid pulses.
//      rd_data = 0x00, 0x11, ..., 0x77 in order, for PIPE=0 and PIPE=1.

Source files
------------

// File: rtl/reg_mux_bank.sv
// reg_mux_bank: 2**SEL_BITS enable-gated registers with valid flags, mux-tree read port; latency 1+PIPE, a read every cycle, no backpressure.
// REG_MUX_BANK_BYPASS_EN: same-cycle write to the read address is forwarded to the read (write-through).
module reg_mux_bank #(
  parameter int SEL_BITS   = 3,
  parameter int DATA_WIDTH = 8,
  parameter int PIPE       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [SEL_BITS-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  inv_en,
  input  logic [SEL_BITS-1:0]   inv_addr,
  input  logic                  rd_en,
  input  logic [SEL_BITS-1:0]   rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_hit
);

  localparam int DEPTH = 2**SEL_BITS;
  localparam int NW    = DATA_WIDTH + 1;
  // Levels resolved before the pipeline register: levels 0..floor(SEL_BITS/2), capped at the tree height.
  localparam int HALF  = SEL_BITS / 2 + 1;
  localparam int FRONT = (PIPE == 1) ? ((HALF < SEL_BITS) ? HALF : SEL_BITS) : SEL_BITS;
  localparam int MID   = DEPTH >> FRONT;

  generate
    if (PIPE != 0 && PIPE != 1) begin : g_bad_pipe
      $error("reg_mux_bank: PIPE must be 0 or 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic [DEPTH-1:0]      vld_nxt;

  // Write is applied after the invalidate so it wins on an address collision.
  always_comb begin
    vld_nxt = vld_q;
    if (inv_en) vld_nxt[inv_addr] = 1'b0;
    if (wr_en)  vld_nxt[wr_addr]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q <= '0;
    end else if (clr) begin
      vld_q <= '0;
    end else begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      vld_q <= vld_nxt;
    end
  end

  // Leaf nodes carry {hit, data}.
  logic [NW-1:0] leaf [DEPTH];
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      leaf[i] = {vld_q[i], mem_q[i]};
`ifdef REG_MUX_BANK_BYPASS_EN
      if (wr_en && wr_addr == SEL_BITS'(i)) begin
        if (clr) leaf[i][NW-1] = 1'b0;
        else     leaf[i]       = {1'b1, wr_data};
      end
`endif
    end
  end

  logic [NW-1:0] ftree [FRONT+1][DEPTH];
  always_comb begin
    for (int l = 0; l <= FRONT; l++)
      for (int j = 0; j < DEPTH; j++) ftree[l][j] = '0;
    for (int j = 0; j < DEPTH; j++) ftree[0][j] = leaf[j];
    for (int l = 0; l < FRONT; l++)
      for (int j = 0; j < (DEPTH >> (l + 1)); j++)
        ftree[l+1][j] = rd_addr[l] ? ftree[l][2*j+1] : ftree[l][2*j];
  end

  logic          res_vld;
  logic [NW-1:0] res_node;

  generate
    if (PIPE == 1) begin : g_pipe
      logic [NW-1:0] mid_node [MID];
      logic          mid_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mid_vld <= 1'b0;
          for (int j = 0; j < MID; j++) mid_node[j] <= '0;
        end else begin
          mid_vld <= rd_en;
          if (rd_en)
            for (int j = 0; j < MID; j++) mid_node[j] <= ftree[FRONT][j];
        end
      end

      if (FRONT < SEL_BITS) begin : g_back
        logic [SEL_BITS-1:FRONT] mid_addr;
        logic [NW-1:0]           btree [SEL_BITS-FRONT+1][MID];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)     mid_addr <= '0;
          else if (rd_en) mid_addr <= rd_addr[SEL_BITS-1:FRONT];
        end

        always_comb begin
          for (int l = 0; l <= SEL_BITS - FRONT; l++)
            for (int j = 0; j < MID; j++) btree[l][j] = '0;
          for (int j = 0; j < MID; j++) btree[0][j] = mid_node[j];
          for (int l = 0; l < SEL_BITS - FRONT; l++)
            for (int j = 0; j < (MID >> (l + 1)); j++)
              btree[l+1][j] = mid_addr[FRONT+l] ? btree[l][2*j+1] : btree[l][2*j];
        end

        assign res_node = btree[SEL_BITS-FRONT][0];
      end else begin : g_noback
        assign res_node = mid_node[0];
      end

      assign res_vld = mid_vld;
    end else begin : g_nopipe
      assign res_vld  = rd_en;
      assign res_node = ftree[SEL_BITS][0];
    end
  endgenerate

  // Data and hit hold their last value between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_hit   <= 1'b0;
    end else begin
      rd_valid <= res_vld;
      if (res_vld) {rd_hit, rd_data} <= res_node;
    end
  end

endmodule
